// File: rtl/pull_fanout_fifo_if.sv
// rtl/pull_fanout_fifo_if.sv - req/ack pull handshake bundle for the fan-out FIFO
interface pull_fanout_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_OUT    = 2
) ();
  logic                          req_l;
  logic                          ack_l;
  logic [DATA_WIDTH-1:0]         din;
  logic [NUM_OUT-1:0]            req_r;
  logic [NUM_OUT-1:0]            ack_r;
  logic [DATA_WIDTH*NUM_OUT-1:0] dout;

  // slave is the FIFO's own view; master is whatever drives it
  modport slave  (output req_l, ack_r, dout, input  ack_l, din, req_r);
  modport master (input  req_l, ack_r, dout, output ack_l, din, req_r);
endinterface

// File: rtl/pull_fanout_fifo.sv
// rtl/pull_fanout_fifo.sv - buffered pull fan-out: one upstream requester, NUM_OUT independent readers
// Optional token counters under PULL_FANOUT_FIFO_COUNT_EN.
module pull_fanout_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int NUM_OUT    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  pull_fanout_fifo_if.slave      bus
`ifdef PULL_FANOUT_FIFO_COUNT_EN
  ,
  output logic [31:0]            count_in,
  output logic [32*NUM_OUT-1:0]  count_out
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [DATA_WIDTH-1:0]              mem_q [DEPTH];
  logic [PW-1:0]                      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                      rd_ptr_q [NUM_OUT];
  logic [PW-1:0]                      rd_ptr_d [NUM_OUT];
  logic [PW-1:0]                      occ      [NUM_OUT];
  logic [PW-1:0]                      occ_post [NUM_OUT];
  logic                               req_l_q, req_l_d;
  logic [NUM_OUT-1:0]                 ack_r_q, ack_r_d;
  logic [NUM_OUT-1:0][DATA_WIDTH-1:0] dout_q, dout_d;
  logic                               wr_fire;
  logic [NUM_OUT-1:0]                 rd_fire;
  logic [PW-1:0]                      occ_max, occ_max_post;

  // Occupancy is per reader; the slowest reader (largest occupancy) decides fullness.
  always_comb begin
    wr_fire      = bus.ack_l & req_l_q;
    wr_ptr_d     = wr_ptr_q + PW'(wr_fire);
    rd_fire      = '0;
    ack_r_d      = '0;
    dout_d       = dout_q;
    occ_max      = '0;
    occ_max_post = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      occ[i]      = wr_ptr_q - rd_ptr_q[i];
      rd_fire[i]  = bus.req_r[i] & ~ack_r_q[i] & (occ[i] != '0);
      rd_ptr_d[i] = rd_ptr_q[i] + PW'(rd_fire[i]);
      occ_post[i] = wr_ptr_d - rd_ptr_d[i];
      ack_r_d[i]  = rd_fire[i];
      if (rd_fire[i]) dout_d[i] = mem_q[rd_ptr_q[i][AW-1:0]];
      if (occ[i] > occ_max) occ_max = occ[i];
      if (occ_post[i] > occ_max_post) occ_max_post = occ_post[i];
    end
    // An outstanding request is only withdrawn by the write that answers it.
    if (req_l_q) req_l_d = wr_fire ? (occ_max_post < DEPTH_P) : 1'b1;
    else         req_l_d = (occ_max < DEPTH_P);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      req_l_q  <= 1'b0;
      ack_r_q  <= '0;
      dout_q   <= '0;
      for (int i = 0; i < NUM_OUT; i++) rd_ptr_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      req_l_q  <= req_l_d;
      ack_r_q  <= ack_r_d;
      dout_q   <= dout_d;
      for (int i = 0; i < NUM_OUT; i++) rd_ptr_q[i] <= rd_ptr_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= bus.din;
  end

  assign bus.req_l = req_l_q;
  assign bus.ack_r = ack_r_q;
  assign bus.dout  = dout_q;

`ifdef PULL_FANOUT_FIFO_COUNT_EN
  logic [31:0]                count_in_q;
  logic [NUM_OUT-1:0][31:0]   count_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_in_q  <= '0;
      count_out_q <= '0;
    end else begin
      count_in_q <= count_in_q + 32'(wr_fire);
      for (int i = 0; i < NUM_OUT; i++) count_out_q[i] <= count_out_q[i] + 32'(rd_fire[i]);
    end
  end

  assign count_in  = count_in_q;
  assign count_out = count_out_q;
`endif
endmodule

// File: tb/tb_pull_fanout_fifo.sv
// tb/tb_pull_fanout_fifo.sv - self-checking bench for pull_fanout_fifo (DEPTH=4, NUM_OUT=2)
module tb_pull_fanout_fifo;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int NO    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pull_fanout_fifo_if #(.DATA_WIDTH(DW), .NUM_OUT(NO)) bus ();
`ifdef PULL_FANOUT_FIFO_COUNT_EN
  logic [31:0] count_in;
  logic [63:0] count_out;
`endif

  pull_fanout_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_OUT(NO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef PULL_FANOUT_FIFO_COUNT_EN
    ,
    .count_in(count_in),
    .count_out(count_out)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference model: token list plus per-reader delivered counts.
  logic        m_valid = 1'b0;
  logic        m_req_l;
  logic [1:0]  m_ack;
  logic [31:0] m_dout [2];
  int          nwr;
  int          nrd [2];
  logic [31:0] tok [$];
  logic [31:0] rx0 [$];
  logic [31:0] rx1 [$];
  int          ac0 [$];
  int          cyc = 0;
  bit          m_wr;
  int          m_pre;

  function automatic int occmax();
    return ((nwr - nrd[0]) > (nwr - nrd[1])) ? (nwr - nrd[0]) : (nwr - nrd[1]);
  endfunction

  initial forever begin
    @(negedge clk);
    cyc++;
    if (m_valid) begin
      chk("req_l", bus.req_l, m_req_l);
      chk("ack_r", bus.ack_r, m_ack);
      chk("dout", bus.dout, {m_dout[1], m_dout[0]});
      chk("req_l_while_full", bus.req_l && (occmax() == DEPTH), 0);
    end
    if (bus.ack_r[0] === 1'b1) begin rx0.push_back(bus.dout[31:0]); ac0.push_back(cyc); end
    if (bus.ack_r[1] === 1'b1) rx1.push_back(bus.dout[63:32]);
    if (rst) begin
      m_valid = 1'b1;
      m_req_l = 1'b0;
      m_ack   = 2'b00;
      m_dout[0] = '0;
      m_dout[1] = '0;
      nwr = 0;
      nrd[0] = 0;
      nrd[1] = 0;
      tok.delete();
    end else if (m_valid) begin
      m_pre = occmax();
      m_wr  = bus.ack_l && m_req_l;
      for (int i = 0; i < 2; i++) begin
        if (bus.req_r[i] && !m_ack[i] && nwr > nrd[i]) begin
          m_dout[i] = tok[nrd[i]];
          nrd[i]++;
          m_ack[i] = 1'b1;
        end else begin
          m_ack[i] = 1'b0;
        end
      end
      if (m_wr) begin tok.push_back(bus.din); nwr++; end
      if (m_req_l) m_req_l = m_wr ? (occmax() < DEPTH) : 1'b1;
      else         m_req_l = (m_pre < DEPTH);
    end
  end

  // Stimulus: upstream responder acks only while its own ack is low.
  logic [31:0] prod_val;
  int          prod_left = 0;
  bit          rand_req  = 0;
  bit          rand_prod = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (prod_left > 0 && bus.req_l && !bus.ack_l && (!rand_prod || $urandom_range(0, 1) == 1)) begin
      bus.ack_l = 1'b1;
      bus.din   = prod_val;
      prod_val++;
      prod_left--;
    end else begin
      bus.ack_l = 1'b0;
    end
    if (rand_req) bus.req_r = {($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0)};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ack_l = 1'b0;
    bus.din   = '0;
    bus.req_r = '0;
    prod_left = 0;
    rand_req  = 0;
    rand_prod = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_rx(input int n0, input int n1, input int budget, input string name);
    int k = 0;
    while ((rx0.size() < n0 || rx1.size() < n1) && k < budget) begin
      tick();
      k++;
    end
    chk(name, (rx0.size() >= n0) && (rx1.size() >= n1), 1);
  endtask

  function automatic int seq_errs(input int which, input int mark, input logic [31:0] base, input int n);
    int e = 0;
    logic [31:0] v;
    for (int k = 0; k < n; k++) begin
      v = (which == 0) ? rx0[mark + k] : rx1[mark + k];
      if (v !== base + 32'(k)) e++;
    end
    return e;
  endfunction

  int m0, m1, fa, fr, k;

  initial begin
    do_reset();
    chk("rst_req_l", bus.req_l, 0);
    chk("rst_ack_r", bus.ack_r, 0);
    chk("rst_dout", bus.dout, 0);

    // basic order with both readers always requesting
    m0 = rx0.size(); m1 = rx1.size();
    prod_val = 0; prod_left = 100; bus.req_r = 2'b11;
    wait_rx(m0 + 100, m1 + 100, 2000, "basic_done");
    chk("basic_seq0", seq_errs(0, m0, 0, 100), 0);
    chk("basic_seq1", seq_errs(1, m1, 0, 100), 0);
    chk("basic_rate", ac0[m0 + 90] - ac0[m0 + 50], 80);

    // single-token latency
    do_reset();
    bus.req_r = 2'b11;
    k = 0;
    while (!bus.req_l && k < 10) begin tick(); k++; end
    chk("lat_req_l", bus.req_l, 1);
    bus.ack_l = 1'b1; bus.din = 32'hA5;
    tick();
    chk("lat_t1_ack", bus.ack_r, 2'b00);
    tick();
    chk("lat_t2_ack", bus.ack_r, 2'b11);
    chk("lat_t2_dout", bus.dout, {32'hA5, 32'hA5});

    // slow branch fills the buffer
    do_reset();
    m0 = rx0.size();
    prod_val = 10; prod_left = 1000; bus.req_r = 2'b01;
    repeat (40) tick();
    chk("slow_cnt0", rx0.size() - m0, 4);
    chk("slow_seq0", seq_errs(0, m0, 10, 4), 0);
    chk("slow_req_l", bus.req_l, 0);
    m1 = rx1.size();
    bus.req_r = 2'b11;
    fa = -1; fr = -1;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (bus.ack_r[1] && fa < 0) fa = j;
      if (bus.req_l && fr < 0) fr = j;
    end
    chk("slow_first_ack1", fa, 0);
    chk("slow_req_l_rise", fr, 1);
    wait_rx(0, m1 + 4, 50, "slow_done1");
    chk("slow_seq1", seq_errs(1, m1, 10, 4), 0);

    // reset with tokens buffered and a request outstanding
    do_reset();
    prod_val = 100; prod_left = 3; bus.req_r = 2'b00;
    repeat (12) tick();
    chk("mid_req_l", bus.req_l, 1);
    rst = 1'b1; bus.ack_l = 1'b1; bus.din = 32'hDEAD;
    tick();
    rst = 1'b0;
    chk("mid_rst_req_l", bus.req_l, 0);
    chk("mid_rst_ack_r", bus.ack_r, 0);
    chk("mid_rst_dout", bus.dout, 0);
    m0 = rx0.size(); m1 = rx1.size();
    prod_val = 200; prod_left = 5; bus.req_r = 2'b11;
    wait_rx(m0 + 1, m1 + 1, 30, "mid_resume");
    chk("mid_first0", rx0[m0], 200);
    chk("mid_first1", rx1[m1], 200);

    // long random run exercising pointer wrap
    do_reset();
    m0 = rx0.size(); m1 = rx1.size();
    prod_val = 0; prod_left = 1000; rand_req = 1; rand_prod = 1;
    wait_rx(m0 + 1000, m1 + 1000, 20000, "wrap_done");
    rand_req = 0;
    chk("wrap_seq0", seq_errs(0, m0, 0, 1000), 0);
    chk("wrap_seq1", seq_errs(1, m1, 0, 1000), 0);

    // fifty tokens fully drained
    do_reset();
    m0 = rx0.size(); m1 = rx1.size();
    prod_val = 0; prod_left = 50; bus.req_r = 2'b11;
    wait_rx(m0 + 50, m1 + 50, 500, "drain_done");
    repeat (4) tick();
    chk("drain_seq0", seq_errs(0, m0, 0, 50), 0);
    chk("drain_seq1", seq_errs(1, m1, 0, 50), 0);
`ifdef PULL_FANOUT_FIFO_COUNT_EN
    chk("count_in", count_in, 50);
    chk("count_out", count_out, {32'd50, 32'd50});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
